// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the decoupled instruction fetch front end.
// Holds the NOP encoding, the queued entry layout and counter width derivation.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
    localparam int          XLEN                = 32;
    localparam int          FETCH_DEPTH         = 4;
    localparam int          FETCH_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int QCNT_W = cnt_width(FETCH_DEPTH);
    localparam int OCNT_W = cnt_width(FETCH_MAX_OUTSTANDING);

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous first-word-fall-through FIFO with clear; head is valid whenever count != 0.
// Push data is visible at the head one cycle after the push; clear dominates push and pop.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled fetch: issues sequential PCs to a variable-latency imem, queues responses for IF/ID.
// Request to validF is 2 cycles minimum; issue is credit-limited so every kept response has a slot.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH      = XLEN,
    parameter int                    DEPTH           = FETCH_DEPTH,
    parameter int                    MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic [DATA_WIDTH-1:0] pcF,
    output logic [DATA_WIDTH-1:0] pc_plus4F,
    output logic                  validF
);

    localparam int QW = cnt_width(DEPTH);
    localparam int OW = cnt_width(MAX_OUTSTANDING);
    localparam int SW = ((QW > OW) ? QW : OW) + 1;

    logic                  run;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         discard_cnt;
    logic [QW-1:0]         q_count;
    logic [OW-1:0]         s_count;
    logic [DATA_WIDTH-1:0] shadow_head;
    fetch_entry_t          q_head;
    fetch_entry_t          q_in;
    logic [SW-1:0]         credit_used;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  rsp_keep;

    // Slots already spoken for: queued entries plus responses that will not be discarded.
    assign credit_used = SW'(q_count) + SW'(outstanding) - SW'(discard_cnt);

    assign imem_req_valid = run && !redirect
                         && (outstanding < OW'(MAX_OUTSTANDING))
                         && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep = rsp_fire && (discard_cnt == '0) && !redirect;
    assign q_in     = '{pc: shadow_head, instr: imem_rsp_data};

    prefetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (OW)
    ) u_shadow_q (
        .clk      (clk),
        .rst      (rst),
        .push     (req_fire),
        .push_dat (fetch_pc),
        .pop      (rsp_keep && (s_count != '0)),
        .clear    (redirect),
        .count    (s_count),
        .head     (shadow_head)
    );

    prefetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (QW)
    ) u_entry_q (
        .clk      (clk),
        .rst      (rst),
        .push     (rsp_keep),
        .push_dat (q_in),
        .pop      (validF && en && !redirect),
        .clear    (redirect),
        .count    (q_count),
        .head     (q_head)
    );

    assign validF    = (q_count != '0);
    assign instrF    = validF ? q_head.instr : NOP_INSTR;
    assign pcF       = validF ? q_head.pc : '0;
    assign pc_plus4F = pcF + DATA_WIDTH'(4);

    // run holds off issue until the first edge after reset so req_valid drops asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_fire);
            if (redirect) begin
                fetch_pc    <= redirect_pc;
                discard_cnt <= outstanding - OW'(rsp_fire);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                if (rsp_fire && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
            end
        end
    end

    rsp_without_request: assert property (
        @(posedge clk) disable iff (!rst) imem_rsp_valid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a scoreboard of expected {pc, instr} entries
// and an in-order imem model with configurable latency, response hold and request stall.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic        validF;

    int           checks = 0;
    int           errors = 0;
    int           pops   = 0;
    int           hs_cnt = 0;
    int           cyc    = 0;
    int           lat    = 1;
    logic         mem_hold = 1'b0;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;
    logic [31:0]  pend_q[$];
    int           due_q[$];
    bit           ok;
    int           p0;

    always #5 clk = ~clk;

    fetch_prefetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instrF         (instrF),
        .pcF            (pcF),
        .pc_plus4F      (pc_plus4F),
        .validF         (validF)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Anything not yet consumed is flushed by a redirect or reset; restart the expected stream.
    task automatic expect_stream(input logic [31:0] start, input int n);
        fetch_entry_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input string name, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            smp();
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: no request handshake within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_valid(input string name, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            smp();
            if (validF) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: validF not seen within %0d cycles", name, budget);
        end
    endtask

    // In-order instruction memory: a request accepted in cycle c answers in cycle c+lat or later.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (!rst) begin
                pend_q.delete();
                due_q.delete();
                imem_rsp_valid = 1'b0;
            end else if (!mem_hold && (pend_q.size() != 0) && (due_q[0] <= cyc)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (rst && imem_req_valid && imem_req_ready) begin
                pend_q.push_back(imem_req_addr);
                due_q.push_back(cyc + lat);
                hs_cnt++;
            end
        end
    end

    // Scoreboard monitor: an entry is consumed at the next edge when validF && en and no redirect.
    always @(negedge clk) begin
        if (rst && validF && en && !redirect) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h, expected no entry", pcF);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc", pcF, mon_e.pc);
                check("sb_instr", instrF, mon_e.instr);
                check("sb_pc_plus4", pc_plus4F, mon_e.pc + 32'd4);
            end
        end else if (rst && !validF) begin
            check("idle_nop", instrF, NOP_INSTR);
        end
    end

    initial begin
        rst            = 1'b0;
        en             = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        expect_stream(32'h0, 64);
        #3;
        check_bit("rst_validF", validF, 1'b0);
        check("rst_instrF", instrF, NOP_INSTR);
        check("rst_pcF", pcF, 32'h0);
        check("rst_pc_plus4F", pc_plus4F, 32'h4);
        check_bit("rst_req_valid", imem_req_valid, 1'b0);
        tick();
        tick();
        rst = 1'b1;

        // First handshake latency, then fill under en = 0.
        wait_req("first_req", 10, ok);
        if (ok) begin
            check("first_addr", imem_req_addr, 32'h0);
            smp();
            check_bit("lat_validF_n1", validF, 1'b0);
            smp();
            check_bit("lat_validF_n2", validF, 1'b1);
            check("lat_pcF", pcF, 32'h0);
        end
        repeat (8) smp();
        check_bit("bp_req_valid", imem_req_valid, 1'b0);
        check("bp_handshakes", 32'(hs_cnt), 32'd4);
        check("bp_head_pc", pcF, 32'h0);
        check("bp_head_instr", instrF, 32'hC0DE_0000);

        // Release backpressure; the stream must run one per cycle.
        tick();
        en = 1'b1;
        repeat (4) smp();
        p0 = pops;
        repeat (16) smp();
        check("stream_rate", 32'(pops - p0), 32'd16);

        // Redirect with two requests in flight and no response in the redirect cycle.
        tick();
        mem_hold = 1'b1;
        repeat (6) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        expect_stream(32'h0000_0100, 64);
        smp();
        check_bit("redir_no_req", imem_req_valid, 1'b0);
        tick();
        redirect = 1'b0;
        mem_hold = 1'b0;
        smp();
        check_bit("redir_validF_low", validF, 1'b0);
        wait_valid("redir_first", 20, ok);
        if (ok) begin
            check("redir_pcF", pcF, 32'h0000_0100);
            check("redir_pc_plus4F", pc_plus4F, 32'h0000_0104);
        end

        // Redirect coinciding with a response, a pending pop and two outstanding requests.
        repeat (6) tick();
        en       = 1'b0;
        mem_hold = 1'b1;
        repeat (6) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        en          = 1'b1;
        mem_hold    = 1'b0;
        expect_stream(32'h0000_0200, 64);
        smp();
        check_bit("simul_no_req", imem_req_valid, 1'b0);
        check_bit("simul_head_held", validF, 1'b1);
        check_bit("simul_rsp_present", imem_rsp_valid, 1'b1);
        tick();
        redirect = 1'b0;
        smp();
        check_bit("simul_queue_empty", validF, 1'b0);
        check_bit("simul_req_valid", imem_req_valid, 1'b1);
        check("simul_req_addr", imem_req_addr, 32'h0000_0200);
        wait_valid("simul_first", 20, ok);
        if (ok) check("simul_pcF", pcF, 32'h0000_0200);

        // Memory stall with a wrapping redirect target.
        repeat (4) tick();
        imem_req_ready = 1'b0;
        repeat (8) tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        expect_stream(32'hFFFF_FFFC, 64);
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            smp();
            check_bit("stall_req_valid", imem_req_valid, 1'b1);
            check("stall_addr", imem_req_addr, 32'hFFFF_FFFC);
        end
        tick();
        imem_req_ready = 1'b1;
        smp();
        check("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
        smp();
        check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        wait_valid("wrap_first", 20, ok);
        if (ok) begin
            check("wrap_pcF", pcF, 32'hFFFF_FFFC);
            check("wrap_pc_plus4F", pc_plus4F, 32'h0000_0000);
        end

        // Asynchronous reset between edges while streaming.
        repeat (6) tick();
        @(posedge clk);
        #3;
        check_bit("pre_arst_validF", validF, 1'b1);
        rst = 1'b0;
        expect_stream(32'h0, 64);
        #1;
        check_bit("arst_validF", validF, 1'b0);
        check_bit("arst_req_valid", imem_req_valid, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        wait_req("post_rst_req", 10, ok);
        if (ok) check("post_rst_addr", imem_req_addr, 32'h0);
        p0 = pops;
        repeat (12) smp();
        check_bit("post_rst_streaming", (pops - p0) >= 8, 1'b1);

        tick();
        en = 1'b0;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
